color_detect_multi: RTL and testbench
=====================================

# color_detect_multi

Parametrised multi-class HSV colour classifier sitting directly after the RGB-to-HSV converter in the video pipeline, replacing the single fixed-threshold detector. Each of NUM_CLASS classes has a programmable hue/saturation/value window (hue window may wrap through 0). Every active pixel gets a per-class hit mask and a priority-encoded class ID, with sync signals delayed to match. Optional per-frame pixel counters per class feed the tracking firmware.

## Interface
- NUM_CLASS, 4: number of colour classes, 1..8.
- CLS_W, 3: class index width, must satisfy 2^CLS_W >= NUM_CLASS.
- CNT_W, 22: per-class frame counter width.
- clk  input  1  pixel clock.
- rst  input  1  asynchronous, active-low reset.
- hsv_hs, hsv_vs, hsv_de  input  1 each  syncs from HSV stage; frame start = rising edge of hsv_vs.
- hsv  input  24  {hue[23:16], sat[15:8], val[7:0]}.
- cfg_we  input  1  write strobe for one class window into the shadow bank.
- cfg_class  input  CLS_W  class written; values >= NUM_CLASS are ignored.
- cfg_data  input  49  {en[48], h_lo[47:40], h_hi[39:32], s_lo[31:24], s_hi[23:16], v_lo[15:8], v_hi[7:0]}.
- color_hs, color_vs, color_de  output  1 each  syncs delayed 2 cycles.
- color_mask  output  NUM_CLASS  bit k = pixel inside enabled window k.
- color_hit  output  1  OR of color_mask.
- color_id  output  CLS_W  lowest set index in color_mask; 0 when color_hit=0.
- frame_cnt  output  NUM_CLASS*CNT_W  class k at [k*CNT_W +: CNT_W]; last completed frame counts.
- cnt_valid  output  1  one-cycle pulse when frame_cnt updates.

## Operation
- Two window banks: shadow (written by cfg_we, one class per cycle) and active (used for comparison). Active bank copies the whole shadow bank on the cycle the hsv_vs rising edge is detected; no mid-frame window change.
- Reset contents, both banks: class 0 = {en=1, h 0..255, s 80..255, v 180..255} (legacy detector behaviour); all other classes en=0, remaining fields 0.
- Match k = en_k & s_lo<=sat<=s_hi & v_lo<=val<=v_hi & hue_ok. hue_ok = (h_lo<=hue<=h_hi) when h_lo<=h_hi, else (hue>=h_lo | hue<=h_hi) (wrap). All compares unsigned 8-bit, inclusive.
- Masks are qualified by de: when stage-1 de=0, mask is forced to 0.
- Stage 1: register per-class match bits and syncs. Stage 2: register color_mask, color_hit, priority-encoded color_id, syncs.
- cfg_we coinciding with the vs-edge copy: active bank receives the pre-write shadow value; the write lands in shadow and applies next frame.

## Timing
- Latency 2 cycles from hsv/hsv_* to every output; full throughput, one pixel per cycle, no stall.
- Reset: all outputs 0; pipeline and counters cleared; vs edge detector cleared (vs high out of reset is not an edge).
- Counters (when compiled in): accumulate on stage-2 outputs; count_k += 1 when color_de & color_mask[k]; saturate at 2^CNT_W-1.
- On rising edge of color_vs: frame_cnt <= accumulators (including a pixel counted that same cycle), accumulators cleared, cnt_valid=1 for that cycle. A hit coinciding with the edge cycle is counted into the closing frame.
- First frame after reset publishes counts of any partial frame seen.

## Configuration
- COLOR_DETECT_COUNT_EN defined: per-class frame counters, frame_cnt and cnt_valid as above.
- Not defined: no counter logic; frame_cnt tied 0, cnt_valid tied 0; classification path unchanged.

## Test plan
- Reset defaults: no cfg writes, pixel {h=10,s=80,v=180} de=1 -> 2 cycles later color_mask=0001, color_hit=1, color_id=0; {s=79} -> mask 0.
- Hue wrap: class 1 {en,h 240..15, s/v 0..255}; hue 250, 0, 15 -> bit1 set; hue 16, 239 -> bit1 clear.
- Priority/overlap: classes 1 and 3 both match -> color_mask=1010, color_id=1; de=0 same pixel -> mask 0, id 0.
- Shadow bank: write class 2 mid-frame -> no change in that frame; after hsv_vs rise, class 2 hits; write on exact edge cycle applies only from the following frame.
- Counters (macro on): frame of 100 de pixels, 37 hitting class 0 -> at color_vs rise cnt_valid pulses once, frame_cnt[0]=37, others 0; CNT_W=4 with 20 hits -> 15.
- Async reset asserted mid-frame -> all outputs 0 immediately, windows back to defaults, counters 0.

Source files
------------

// File: rtl/color_detect_multi.sv
// color_detect_multi: multi-class HSV window classifier with shadow/active banks and a 2-cycle pipeline.
// Define COLOR_DETECT_COUNT_EN to add per-class per-frame hit counters (frame_cnt/cnt_valid).
module color_detect_multi #(
  parameter int NUM_CLASS = 4,
  parameter int CLS_W     = 3,
  parameter int CNT_W     = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hsv_hs,
  input  logic                       hsv_vs,
  input  logic                       hsv_de,
  input  logic [23:0]                hsv,
  input  logic                       cfg_we,
  input  logic [CLS_W-1:0]           cfg_class,
  input  logic [48:0]                cfg_data,
  output logic                       color_hs,
  output logic                       color_vs,
  output logic                       color_de,
  output logic [NUM_CLASS-1:0]       color_mask,
  output logic                       color_hit,
  output logic [CLS_W-1:0]           color_id,
  output logic [NUM_CLASS*CNT_W-1:0] frame_cnt,
  output logic                       cnt_valid
);
  localparam logic [48:0] DEF0 = {1'b1, 8'd0, 8'd255, 8'd80, 8'd255, 8'd180, 8'd255};
  logic [48:0] sh_q [NUM_CLASS];
  logic [48:0] sh_d [NUM_CLASS];
  logic [48:0] act_q [NUM_CLASS];
  logic [NUM_CLASS-1:0] match, m1_q, m1_de, mask_q;
  logic vs_q, vs_rise, hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q, hit_q;
  logic [CLS_W-1:0] id_d, id_q;
  logic [7:0] hue, sat, val;
  assign {hue, sat, val} = hsv;
  assign vs_rise = hsv_vs & ~vs_q;
  assign m1_de = m1_q & {NUM_CLASS{de1_q}};
  genvar k;
  generate
    for (k = 0; k < NUM_CLASS; k++) begin : g_cls
      logic [48:0] w;
      logic hue_ok;
      assign w = act_q[k];
      assign hue_ok = (w[47:40] <= w[39:32]) ? (hue >= w[47:40] && hue <= w[39:32])
                                             : (hue >= w[47:40] || hue <= w[39:32]);
      assign match[k] = w[48] && hue_ok && sat >= w[31:24] && sat <= w[23:16]
                        && val >= w[15:8] && val <= w[7:0];
      assign sh_d[k] = (cfg_we && cfg_class == CLS_W'(k)) ? cfg_data : sh_q[k];
    end
  endgenerate
  always_comb begin
    id_d = '0;
    for (int i = NUM_CLASS - 1; i >= 0; i--) if (m1_de[i]) id_d = CLS_W'(i);
  end
  // vs_q resets high so a vs already high out of reset is not seen as a frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        sh_q[i]  <= (i == 0) ? DEF0 : '0;
        act_q[i] <= (i == 0) ? DEF0 : '0;
      end
      vs_q   <= 1'b1;
      m1_q   <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
      mask_q <= '0;
      hit_q  <= 1'b0;
      id_q   <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      de2_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        sh_q[i] <= sh_d[i];
        if (vs_rise) act_q[i] <= sh_q[i];
      end
      vs_q   <= hsv_vs;
      m1_q   <= match;
      hs1_q  <= hsv_hs;
      vs1_q  <= hsv_vs;
      de1_q  <= hsv_de;
      mask_q <= m1_de;
      hit_q  <= |m1_de;
      id_q   <= id_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= de1_q;
    end
  end
  assign color_hs   = hs2_q;
  assign color_vs   = vs2_q;
  assign color_de   = de2_q;
  assign color_mask = mask_q;
  assign color_hit  = hit_q;
  assign color_id   = id_q;
`ifdef COLOR_DETECT_COUNT_EN
  logic [NUM_CLASS*CNT_W-1:0] acc_q, acc_d, cnt_q;
  logic cvs_q, cv_q, cvs_rise;
  assign cvs_rise = color_vs & ~cvs_q;
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NUM_CLASS; i++)
      acc_d[i*CNT_W +: CNT_W] = (&acc_q[i*CNT_W +: CNT_W]) ? acc_q[i*CNT_W +: CNT_W]
                                : acc_q[i*CNT_W +: CNT_W] + CNT_W'(color_de & color_mask[i]);
  end
  // the hit on the closing edge cycle is already in acc_d, so it lands in the published frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      cvs_q <= 1'b0;
      cv_q  <= 1'b0;
    end else begin
      acc_q <= cvs_rise ? '0 : acc_d;
      if (cvs_rise) cnt_q <= acc_d;
      cvs_q <= color_vs;
      cv_q  <= cvs_rise;
    end
  end
  assign frame_cnt = cnt_q;
  assign cnt_valid = cv_q;
`else
  assign frame_cnt = '0;
  assign cnt_valid = 1'b0;
`endif
endmodule

// File: tb/tb_color_detect_multi.sv
// tb_color_detect_multi: directed vectors for color_detect_multi (second instance uses CNT_W=4 for saturation).
module tb_color_detect_multi;
  localparam int NC = 4, CW = 3, KW = 22;
  logic clk = 0, rst = 0, hs = 0, vs = 0, de = 0, we = 0;
  logic [23:0] hsv = '0;
  logic [CW-1:0] cls = '0;
  logic [48:0] cd = '0;
  logic c_hs, c_vs, c_de, hit, cval;
  logic [NC-1:0] mask;
  logic [CW-1:0] id;
  logic [NC*KW-1:0] fcnt, fcnt_cap;
  logic s_hs, s_vs, s_de, s_hit, s_cval;
  logic [NC-1:0] s_mask;
  logic [CW-1:0] s_id;
  logic [NC*4-1:0] s_fcnt, s_cap;
  int checks = 0, errors = 0, n_valid;
  color_detect_multi #(.NUM_CLASS(NC), .CLS_W(CW), .CNT_W(KW)) u_dut (
    .clk(clk), .rst(rst), .hsv_hs(hs), .hsv_vs(vs), .hsv_de(de), .hsv(hsv),
    .cfg_we(we), .cfg_class(cls), .cfg_data(cd),
    .color_hs(c_hs), .color_vs(c_vs), .color_de(c_de), .color_mask(mask),
    .color_hit(hit), .color_id(id), .frame_cnt(fcnt), .cnt_valid(cval));
  color_detect_multi #(.NUM_CLASS(NC), .CLS_W(CW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .hsv_hs(hs), .hsv_vs(vs), .hsv_de(de), .hsv(hsv),
    .cfg_we(we), .cfg_class(cls), .cfg_data(cd),
    .color_hs(s_hs), .color_vs(s_vs), .color_de(s_de), .color_mask(s_mask),
    .color_hit(s_hit), .color_id(s_id), .frame_cnt(s_fcnt), .cnt_valid(s_cval));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [7:0] h, s, v, input logic d);
    hsv = {h, s, v};
    de = d;
    tick();
    tick();
  endtask
  task automatic wr(input logic [CW-1:0] c, input logic [48:0] data);
    we = 1;
    cls = c;
    cd = data;
    tick();
    we = 0;
  endtask
  task automatic frame();
    vs = 1;
    tick();
    vs = 0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_mask", mask, 0);
    chk("rst_hit", hit, 0);
    chk("rst_de", c_de, 0);
    chk("rst_cnt", fcnt, 0);
    rst = 1;
    hs = 1;
    pix(8'd10, 8'd80, 8'd180, 1);
    chk("def_mask", mask, 4'b0001);
    chk("def_hit", hit, 1);
    chk("def_id", id, 0);
    chk("def_hs", c_hs, 1);
    chk("def_de", c_de, 1);
    hs = 0;
    pix(8'd10, 8'd79, 8'd180, 1);
    chk("def_s79_mask", mask, 0);
    chk("def_s79_hit", hit, 0);
    wr(1, {1'b1, 8'd240, 8'd15, 8'd0, 8'd255, 8'd0, 8'd255});
    wr(3, {1'b1, 8'd0, 8'd255, 8'd0, 8'd100, 8'd0, 8'd100});
    frame();
    pix(8'd250, 8'd50, 8'd50, 1);
    chk("prio_mask", mask, 4'b1010);
    chk("prio_id", id, 1);
    pix(8'd250, 8'd50, 8'd50, 0);
    chk("de0_mask", mask, 0);
    chk("de0_id", id, 0);
    chk("de0_hit", hit, 0);
    pix(8'd0, 8'd50, 8'd50, 1);
    chk("wrap_h0", mask[1], 1);
    pix(8'd15, 8'd50, 8'd50, 1);
    chk("wrap_h15", mask[1], 1);
    pix(8'd16, 8'd50, 8'd50, 1);
    chk("wrap_h16", mask[1], 0);
    pix(8'd239, 8'd50, 8'd50, 1);
    chk("wrap_h239", mask[1], 0);
    pix(8'd240, 8'd50, 8'd50, 1);
    chk("wrap_h240", mask[1], 1);
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("shadow_pre", mask, 4'b0001);
    wr(2, {1'b1, 8'd100, 8'd110, 8'd200, 8'd255, 8'd200, 8'd255});
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("shadow_mid", mask, 4'b0001);
    frame();
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("shadow_new", mask, 4'b0101);
    chk("shadow_id", id, 0);
    vs = 1;
    we = 1;
    cls = 2;
    cd = '0;
    tick();
    vs = 0;
    we = 0;
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("edge_wr_same", mask, 4'b0101);
    frame();
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("edge_wr_next", mask, 4'b0001);
    pix(8'd100, 8'd200, 8'd200, 0);
    frame();
    for (int i = 0; i < 100; i++) begin
      hsv = (i < 37) ? {8'd100, 8'd200, 8'd200} : {8'd100, 8'd200, 8'd10};
      de = 1;
      tick();
    end
    de = 0;
    tick();
    tick();
    tick();
    vs = 1;
    tick();
    vs = 0;
    n_valid = 0;
    fcnt_cap = '0;
    s_cap = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cval) begin
        n_valid++;
        fcnt_cap = fcnt;
        s_cap = s_fcnt;
      end
    end
`ifdef COLOR_DETECT_COUNT_EN
    chk("cnt_pulses", n_valid, 1);
    chk("cnt_c0", fcnt_cap[0 +: KW], 37);
    chk("cnt_c1", fcnt_cap[KW +: KW], 0);
    chk("cnt_c2", fcnt_cap[2*KW +: KW], 0);
    chk("cnt_c3", fcnt_cap[3*KW +: KW], 0);
    chk("cnt_sat_c0", s_cap[3:0], 15);
    chk("cnt_sat_c3", s_cap[15:12], 0);
`else
    chk("cnt_off_pulses", n_valid, 0);
    chk("cnt_off_val", fcnt, 0);
`endif
    pix(8'd100, 8'd200, 8'd200, 1);
    chk("pre_rst_mask", mask, 4'b0001);
    #2;
    rst = 0;
    #1;
    chk("arst_mask", mask, 0);
    chk("arst_hit", hit, 0);
    chk("arst_de", c_de, 0);
    chk("arst_cnt", fcnt, 0);
    chk("arst_valid", cval, 0);
    vs = 1;
    tick();
    tick();
    rst = 1;
    wr(1, {1'b1, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255});
    pix(8'd250, 8'd50, 8'd50, 1);
    chk("vs_hi_no_edge", mask, 0);
    pix(8'd105, 8'd210, 8'd210, 1);
    chk("rst_win_default", mask, 4'b0001);
    vs = 0;
    tick();
    frame();
    pix(8'd250, 8'd50, 8'd50, 1);
    chk("post_rst_frame", mask, 4'b0010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
